fib_serial_ctrl: RTL and testbench



---
 rtl/fib_serial_ctrl_if.sv | 26 ++
 rtl/fib_serial_ctrl.sv | 127 ++++++++++++
 tb/tb_fib_serial_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/fib_serial_ctrl_if.sv
// Host-side handshake bundle for the bit-serial Fibonacci sequencer.
// The host drives start/n/ack; the sequencer drives status and result.
interface fib_serial_ctrl_if #(
    parameter int WIDTH = 16,
    parameter int NW    = 6
);
    logic             start;
    logic [NW-1:0]    n;
    logic             ready;
    logic             busy;
    logic             done;
    logic             ack;
    logic [WIDTH-1:0] result;
    logic             overflow;
    logic [NW-1:0]    step_count;

    modport master (
        output start, n, ack,
        input  ready, busy, done, result, overflow, step_count
    );

    modport slave (
        input  start, n, ack,
        output ready, busy, done, result, overflow, step_count
    );
endinterface

// File: rtl/fib_serial_ctrl.sv
// Fibonacci sequencer: a=F(k), b=F(k+1) advanced by a bit-serial
// ripple add (LSB first, carry in a flop), wrapped in start/done handshakes.
module fib_serial_ctrl #(
    parameter int WIDTH = 16,
    parameter int NW    = 6,
    parameter int BW    = 4
) (
    input logic clk,
    input logic reset,
    fib_serial_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ADD    = 2'd1,
        COMMIT = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic [NW-1:0]    k;
    logic [NW-1:0]    n_reg;
    logic [BW-1:0]    bitcnt;
    logic             ovf;

    logic          abit;
    logic          bbit;
    logic          s;
    logic          cout;
    logic          last_bit;
    logic [NW-1:0] k_next;

    assign abit     = a[bitcnt];
    assign bbit     = b[bitcnt];
    assign s        = abit ^ bbit ^ carry;
    assign cout     = (abit & bbit) | (abit & carry) | (bbit & carry);
    assign last_bit = (bitcnt == BW'(WIDTH - 1));
    assign k_next   = k + NW'(1);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = (bus.n == '0) ? DONE : ADD;
                end
            end
            ADD: begin
                if (last_bit) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                state_d = (k_next == n_reg) ? DONE : ADD;
            end
            DONE: begin
                if (bus.ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a      <= '0;
            b      <= '0;
            sum    <= '0;
            carry  <= 1'b0;
            k      <= '0;
            n_reg  <= '0;
            bitcnt <= '0;
            ovf    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        n_reg  <= bus.n;
                        a      <= '0;
                        b      <= WIDTH'(1);
                        k      <= '0;
                        carry  <= 1'b0;
                        bitcnt <= '0;
                        ovf    <= 1'b0;
                    end
                end
                ADD: begin
                    sum[bitcnt] <= s;
                    carry       <= cout;
                    bitcnt      <= bitcnt + BW'(1);
                    // F(k+2) wrapping only matters if it will become F(n)
                    if (last_bit && cout && (k_next < n_reg)) begin
                        ovf <= 1'b1;
                    end
                end
                COMMIT: begin
                    a      <= b;
                    b      <= sum;
                    k      <= k_next;
                    carry  <= 1'b0;
                    bitcnt <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.ready      = (state_q == IDLE);
    assign bus.busy       = (state_q == ADD) || (state_q == COMMIT);
    assign bus.done       = (state_q == DONE);
    assign bus.result     = a;
    assign bus.overflow   = ovf;
    assign bus.step_count = k;
endmodule

// File: tb/tb_fib_serial_ctrl.sv
// Directed bench for fib_serial_ctrl with WIDTH=16: latency,
// overflow boundary, handshake corner cases and mid-run reset.
module tb_fib_serial_ctrl;
    localparam int WIDTH = 16;
    localparam int NW    = 6;
    localparam int BW    = 4;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    fib_serial_ctrl_if #(.WIDTH(WIDTH), .NW(NW)) bus ();

    fib_serial_ctrl #(.WIDTH(WIDTH), .NW(NW), .BW(BW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, ".ready"}, int'(bus.ready), 1);
        chk({tag, ".busy"}, int'(bus.busy), 0);
        chk({tag, ".done"}, int'(bus.done), 0);
    endtask

    // Issue a request and wait for done; latency counts edges from accept.
    task automatic run(input int n, input int exp_res, input int exp_ovf,
                       input bit noise);
        int lat;
        int busy_cycles;
        bus.start = 1'b1;
        bus.n     = NW'(n);
        tick();
        bus.start   = 1'b0;
        lat         = 1;
        busy_cycles = 0;
        while (!bus.done && lat < 2000) begin
            if (bus.busy) busy_cycles++;
            if (noise && (lat % 5 == 0)) begin
                bus.start = 1'b1;
                bus.n     = NW'(3);
            end else begin
                bus.start = 1'b0;
            end
            tick();
            lat++;
        end
        bus.start = 1'b0;
        chk($sformatf("n%0d.latency", n), lat, 1 + n * (WIDTH + 1));
        chk($sformatf("n%0d.busy_cycles", n), busy_cycles, n * (WIDTH + 1));
        chk($sformatf("n%0d.result", n), int'(bus.result), exp_res);
        chk($sformatf("n%0d.overflow", n), int'(bus.overflow), exp_ovf);
        chk($sformatf("n%0d.step_count", n), int'(bus.step_count), n);
    endtask

    task automatic do_ack(input string tag);
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        check_idle(tag);
    endtask

    initial begin
        logic [WIDTH-1:0] r0;
        logic             o0;
        bit               stable;

        reset     = 1'b1;
        bus.start = 1'b0;
        bus.n     = '0;
        bus.ack   = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check_idle("reset");
        chk("reset.result", int'(bus.result), 0);
        chk("reset.overflow", int'(bus.overflow), 0);
        chk("reset.step_count", int'(bus.step_count), 0);

        // ack outside DONE has no effect
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        check_idle("stray_ack");

        run(0, 0, 0, 1'b0);
        do_ack("ack0");
        run(1, 1, 0, 1'b0);
        do_ack("ack1");

        // n=10 with start pulses (n=3) while busy
        run(10, 55, 0, 1'b1);
        r0     = bus.result;
        o0     = bus.overflow;
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.result !== r0 || bus.overflow !== o0 || bus.done !== 1'b1)
                stable = 1'b0;
        end
        chk("hold.stable", int'(stable), 1);
        chk("hold.result", int'(bus.result), 55);

        // ack together with start: ack wins, start dropped
        bus.ack   = 1'b1;
        bus.start = 1'b1;
        bus.n     = NW'(3);
        tick();
        bus.ack   = 1'b0;
        bus.start = 1'b0;
        check_idle("ack_start");
        tick();
        check_idle("ack_start.next");

        run(24, 46368, 0, 1'b0);
        do_ack("ack24");
        run(25, 9489, 1, 1'b0);
        do_ack("ack25");

        // reset in the 7th ADD cycle of step 5 (cycle T+75)
        bus.start = 1'b1;
        bus.n     = NW'(20);
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 74; i++) tick();
        chk("midrst.busy_before", int'(bus.busy), 1);
        chk("midrst.k_before", int'(bus.step_count), 4);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle("midrst");
        chk("midrst.result", int'(bus.result), 0);
        chk("midrst.overflow", int'(bus.overflow), 0);
        chk("midrst.step_count", int'(bus.step_count), 0);
        run(7, 13, 0, 1'b0);
        do_ack("ack7");

        run(5, 5, 0, 1'b0);
        do_ack("ack5");
        run(6, 8, 0, 1'b0);
        do_ack("ack6");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
